// File: rtl/wb_pkg.sv
// Shared types for the register-file write arbiter: widths, queue entry, winner select.
package wb_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ALU,
        SEL_QUEUE,
        SEL_BYPASS
    } wb_sel_e;

endpackage

// File: rtl/wb_fifo.sv
// In-order LSU result queue (DEPTH power of 2); WB_PEND_FWD_EN exposes all entries
// oldest-first with a valid mask for the pending-write lookup.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  wb_entry_t               push_entry_i,
    input  logic                    pop_i,
    output wb_entry_t               head_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
`ifdef WB_PEND_FWD_EN
    ,
    output wb_entry_t [DEPTH-1:0]   entries_o,
    output logic [DEPTH-1:0]        valid_o
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage needs no reset: only entries below count are ever observed.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

`ifdef WB_PEND_FWD_EN
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entries_o[i] = mem_q[rd_ptr_q + PW'(i)];
            valid_o[i]   = (CW'(i) < count_q);
        end
    end
`endif

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write port driver: ALU results win, LSU results queue in order.
// Optional pending-write forwarding lookup enabled by WB_PEND_FWD_EN.
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_reg,
    input  logic [31:0] lsu_data,
    output logic        RegWrite,
    output logic [4:0]  WriteReg,
    output logic [31:0] WriteData,
    input  logic [4:0]  q1_reg,
    input  logic [4:0]  q2_reg,
    output logic        q1_hit,
    output logic        q2_hit,
    output logic [31:0] q1_data,
    output logic [31:0] q2_data
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 2);

    wb_entry_t              head, win, lsu_entry;
    logic [$clog2(DEPTH):0] count;
    logic                   full, empty, push, pop, lsu_fire;
    wb_sel_e                sel;

    logic [SW-1:0]          starve_q, starve_d;
    logic                   stall_q, stall_d;
    logic                   regwrite_q;
    logic [REG_W-1:0]       wreg_q;
    logic [DATA_W-1:0]      wdata_q;

`ifdef WB_PEND_FWD_EN
    wb_entry_t [DEPTH-1:0]  q_entries;
    logic [DEPTH-1:0]       q_valid;
`endif

    assign lsu_entry = '{dst: lsu_reg, data: lsu_data};
    assign lsu_ready = !rst && !full;
    assign lsu_fire  = lsu_valid && lsu_ready;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i        (clk),
        .rst_i        (rst),
        .push_i       (push),
        .push_entry_i (lsu_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (count),
        .full_o       (full),
        .empty_o      (empty)
`ifdef WB_PEND_FWD_EN
        ,
        .entries_o    (q_entries),
        .valid_o      (q_valid)
`endif
    );

    always_comb begin
        sel = SEL_NONE;
        win = '0;
        pop = 1'b0;
        if (alu_valid) begin
            sel = SEL_ALU;
            win = '{dst: alu_reg, data: alu_data};
        end else if (!empty) begin
            sel = SEL_QUEUE;
            win = head;
            pop = 1'b1;
        end else if (lsu_fire) begin
            sel = SEL_BYPASS;
            win = lsu_entry;
        end
    end

    assign push = lsu_fire && (sel != SEL_BYPASS);

    // Stall follows the next counter value so it rises right after the limiting
    // wait cycle and falls right after the pop that clears the counter.
    always_comb begin
        starve_d = starve_q;
        if (empty || pop) begin
            starve_d = '0;
        end else if (sel == SEL_ALU && starve_q < SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
        stall_d = (starve_d >= SW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q   <= '0;
            stall_q    <= 1'b0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
            if (sel != SEL_NONE) begin
                regwrite_q <= (win.dst != ZERO_REG);
                wreg_q     <= win.dst;
                wdata_q    <= win.data;
            end else begin
                regwrite_q <= 1'b0;
            end
        end
    end

    assign alu_stall = stall_q;
    assign RegWrite  = regwrite_q;
    assign WriteReg  = wreg_q;
    assign WriteData = wdata_q;

`ifdef WB_PEND_FWD_EN
    // Entries arrive oldest-first, so later matches override: bypass > tail > head.
    function automatic logic [DATA_W:0] fwd_lookup(
        input logic [REG_W-1:0]    q,
        input wb_entry_t [DEPTH-1:0] ents,
        input logic [DEPTH-1:0]    vld,
        input logic                byp_v,
        input wb_entry_t           byp
    );
        logic              hit;
        logic [DATA_W-1:0] data;
        hit  = 1'b0;
        data = '0;
        if (q != ZERO_REG) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (vld[i] && ents[i].dst == q) begin
                    hit  = 1'b1;
                    data = ents[i].data;
                end
            end
            if (byp_v && byp.dst == q) begin
                hit  = 1'b1;
                data = byp.data;
            end
        end
        return {hit, data};
    endfunction

    assign {q1_hit, q1_data} = fwd_lookup(q1_reg, q_entries, q_valid, lsu_fire, lsu_entry);
    assign {q2_hit, q2_data} = fwd_lookup(q2_reg, q_entries, q_valid, lsu_fire, lsu_entry);
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^{q1_reg, q2_reg};
    assign q1_hit  = 1'b0;
    assign q2_hit  = 1'b0;
    assign q1_data = '0;
    assign q2_data = '0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: per-cycle vector table plus hand-written
// sequences for stall/reset and the WB_PEND_FWD_EN lookup.
module tb_wb_write_arbiter;

    logic        clk, rst;
    logic        alu_valid, lsu_valid, lsu_ready, alu_stall;
    logic [4:0]  alu_reg, lsu_reg, WriteReg, q1_reg, q2_reg;
    logic [31:0] alu_data, lsu_data, WriteData, q1_data, q2_data;
    logic        RegWrite, q1_hit, q2_hit;

    int n_checks = 0;
    int n_fail   = 0;

    wb_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_reg   (alu_reg),
        .alu_data  (alu_data),
        .alu_stall (alu_stall),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_reg   (lsu_reg),
        .lsu_data  (lsu_data),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .q1_reg    (q1_reg),
        .q2_reg    (q2_reg),
        .q1_hit    (q1_hit),
        .q2_hit    (q2_hit),
        .q1_data   (q1_data),
        .q2_data   (q2_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lr;
        logic [31:0] ld;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        stall;
        logic        rdy;
    } vec_t;

    localparam int unsigned NVEC = 17;
    vec_t tbl [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        alu_valid = av;
        alu_reg   = ar;
        alu_data  = ad;
        lsu_valid = lv;
        lsu_reg   = lr;
        lsu_data  = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_write(input string tag, input logic rw, input logic [4:0] wr,
                             input logic [31:0] wd);
        chk({tag, " RegWrite"}, 32'(RegWrite), 32'(rw));
        chk({tag, " WriteReg"}, 32'(WriteReg), 32'(wr));
        chk({tag, " WriteData"}, WriteData, wd);
    endtask

    initial begin
        //          av  ar     ad            lv  lr     ld           rw  wr     wd           st  rdy
        tbl[0]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,       0, 5'd0,  32'h0,        0, 1};
        tbl[1]  = '{1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,       1, 5'd5,  32'hDEADBEEF, 0, 1};
        tbl[2]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,       0, 5'd5,  32'hDEADBEEF, 0, 1};
        tbl[3]  = '{1, 5'd3,  32'h11,       1, 5'd7,  32'h22,      1, 5'd3,  32'h11,       0, 1};
        tbl[4]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,       1, 5'd7,  32'h22,       0, 1};
        tbl[5]  = '{0, 5'd0,  32'h0,        1, 5'd8,  32'h33,      1, 5'd8,  32'h33,       0, 1};
        tbl[6]  = '{1, 5'd0,  32'h5,        0, 5'd0,  32'h0,       0, 5'd0,  32'h5,        0, 1};
        tbl[7]  = '{0, 5'd0,  32'h0,        1, 5'd0,  32'h44,      0, 5'd0,  32'h44,       0, 1};
        tbl[8]  = '{1, 5'd10, 32'h100,      1, 5'd1,  32'h1001,    1, 5'd10, 32'h100,      0, 1};
        tbl[9]  = '{1, 5'd11, 32'h101,      1, 5'd2,  32'h1002,    1, 5'd11, 32'h101,      0, 1};
        tbl[10] = '{1, 5'd12, 32'h102,      1, 5'd3,  32'h1003,    1, 5'd12, 32'h102,      0, 1};
        tbl[11] = '{1, 5'd13, 32'h103,      1, 5'd4,  32'h1004,    1, 5'd13, 32'h103,      1, 0};
        tbl[12] = '{0, 5'd0,  32'h0,        1, 5'd15, 32'hBAD,     1, 5'd1,  32'h1001,     0, 1};
        tbl[13] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,       1, 5'd2,  32'h1002,     0, 1};
        tbl[14] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,       1, 5'd3,  32'h1003,     0, 1};
        tbl[15] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,       1, 5'd4,  32'h1004,     0, 1};
        tbl[16] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,       0, 5'd4,  32'h1004,     0, 1};

        rst    = 1'b1;
        q1_reg = '0;
        q2_reg = '0;
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        tick();
        tick();
        chk("reset lsu_ready", 32'(lsu_ready), 32'd0);
        chk("reset alu_stall", 32'(alu_stall), 32'd0);
        chk_write("reset", 1'b0, 5'd0, 32'h0);
        rst = 1'b0;
        #1;
        chk("post-reset lsu_ready", 32'(lsu_ready), 32'd1);

        for (int i = 0; i < int'(NVEC); i++) begin
            drive(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].lv, tbl[i].lr, tbl[i].ld);
            tick();
            chk_write($sformatf("row%0d", i), tbl[i].rw, tbl[i].wr, tbl[i].wd);
            chk($sformatf("row%0d alu_stall", i), 32'(alu_stall), 32'(tbl[i].stall));
            chk($sformatf("row%0d lsu_ready", i), 32'(lsu_ready), 32'(tbl[i].rdy));
        end

        // ALU still wins while stalled, then reset discards the three queued loads.
        drive(1, 5'd20, 32'h200, 1, 5'd21, 32'h210); tick();
        drive(1, 5'd22, 32'h220, 1, 5'd23, 32'h230); tick();
        drive(1, 5'd24, 32'h240, 1, 5'd25, 32'h250); tick();
        drive(1, 5'd26, 32'h260, 0, 5'd0,  32'h0);   tick();
        chk("starve alu_stall", 32'(alu_stall), 32'd1);
        drive(1, 5'd27, 32'h270, 0, 5'd0,  32'h0);   tick();
        chk_write("stalled alu", 1'b1, 5'd27, 32'h270);
        chk("stalled alu_stall", 32'(alu_stall), 32'd1);
        drive(0, 5'd0, 32'h0, 1, 5'd28, 32'h280);
        rst = 1'b1;
        #1;
        chk("midrst lsu_ready", 32'(lsu_ready), 32'd0);
        tick();
        chk_write("midrst", 1'b0, 5'd0, 32'h0);
        chk("midrst alu_stall", 32'(alu_stall), 32'd0);
        rst = 1'b0;
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_write($sformatf("discard%0d", i), 1'b0, 5'd0, 32'h0);
            chk($sformatf("discard%0d lsu_ready", i), 32'(lsu_ready), 32'd1);
        end

        // Pending-write lookup: two r9 loads queued behind busy ALU, then a third offered.
        drive(1, 5'd1, 32'h1, 1, 5'd9, 32'hA); tick();
        drive(1, 5'd2, 32'h2, 1, 5'd9, 32'hB); tick();
        drive(1, 5'd3, 32'h3, 0, 5'd0, 32'h0);
        q1_reg = 5'd9;
        q2_reg = 5'd0;
        #1;
`ifdef WB_PEND_FWD_EN
        chk("fwd q1_hit", 32'(q1_hit), 32'd1);
        chk("fwd q1_data", q1_data, 32'hB);
        chk("fwd q2_hit r0", 32'(q2_hit), 32'd0);
        q2_reg = 5'd4;
        #1;
        chk("fwd q2_hit miss", 32'(q2_hit), 32'd0);
        lsu_valid = 1'b1;
        lsu_reg   = 5'd9;
        lsu_data  = 32'hC;
        #1;
        chk("fwd bypass q1_data", q1_data, 32'hC);
        chk("fwd bypass q1_hit", 32'(q1_hit), 32'd1);
`else
        chk("nofwd q1_hit", 32'(q1_hit), 32'd0);
        chk("nofwd q1_data", q1_data, 32'h0);
        chk("nofwd q2_hit", 32'(q2_hit), 32'd0);
        lsu_valid = 1'b1;
        lsu_reg   = 5'd9;
        lsu_data  = 32'hC;
        #1;
        chk("nofwd q2_data", q2_data, 32'h0);
`endif
        tick();
        chk_write("fwd alu", 1'b1, 5'd3, 32'h3);
        q1_reg = '0;
        q2_reg = '0;
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        tick(); chk_write("drain A", 1'b1, 5'd9, 32'hA);
        tick(); chk_write("drain B", 1'b1, 5'd9, 32'hB);
        tick(); chk_write("drain C", 1'b1, 5'd9, 32'hC);
        tick(); chk_write("drain idle", 1'b0, 5'd9, 32'hC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
